// File: rtl/sprite_dma.sv
// Per-frame sprite loader: on each enabled vsync rise, copies NUM_BYTES bytes from memory into the sprite registers.
// Latency: mem_req one cycle after the trigger; per byte 1 REQ cycle plus wait states, then 1 WRITE cycle; done after the last write.
// Backpressure: mem_req/mem_addr are held until mem_ack; vsync rises while not idle are dropped and flagged in overrun.
module sprite_dma #(
  parameter int NUM_BYTES = 10,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vsync,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              we,
  output logic [3:0]        address,
  output logic [7:0]        data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  state_t            state, state_n;
  logic              vsync_d;
  logic              trig;
  logic [3:0]        idx;
  logic [ADDR_W-1:0] base_q;

  assign trig = vsync & ~vsync_d;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (trig && enable) state_n = REQ;
      REQ:     if (mem_ack) state_n = WRITE;
      WRITE:   state_n = (idx == LAST_IDX) ? DONE : REQ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      vsync_d  <= 1'b1;
      idx      <= '0;
      base_q   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      we       <= 1'b0;
      address  <= '0;
      data     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      state   <= state_n;
      mem_req <= (state_n == REQ);
      we      <= (state_n == WRITE);
      busy    <= (state_n == REQ) || (state_n == WRITE);
      done    <= (state_n == DONE);
      if (trig && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (state_n == REQ) begin
            base_q   <= base_addr;
            idx      <= '0;
            mem_addr <= base_addr;
          end
        end
        REQ: begin
          if (mem_ack) begin
            data    <= mem_data;
            address <= idx;
          end
        end
        WRITE: begin
          // Address arithmetic wraps naturally at ADDR_W bits.
          if (state_n == REQ) begin
            idx      <= idx + 4'd1;
            mem_addr <= base_q + ADDR_W'(idx) + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dma.sv
// Bench for sprite_dma: memory responder with programmable wait states, bus monitor, and a
// per-transfer reference model computing expected reads, writes and their cycle numbers.
module tb_sprite_dma;
  localparam int NB = 10;

  logic        clk, reset, enable, vsync;
  logic [15:0] base_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        we;
  logic [3:0]  address;
  logic [7:0]  data;
  logic        busy, done, overrun;

  sprite_dma #(.NUM_BYTES(NB), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .base_addr(base_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .we(we), .address(address), .data(data), .busy(busy), .done(done), .overrun(overrun)
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [7:0]  d;
    logic [31:0] c;
  } w_t;

  logic [7:0]  mem [0:65535];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          delay = 0;
  bit          noise = 0;
  w_t          wr_q[$], exp_w[$];
  logic [15:0] rd_q[$], exp_rd[$];
  int          done_q[$];
  int          exp_done;
  int          req_n, stab_err, busy_err;
  logic        prev_req, prev_busy;
  logic [15:0] prev_addr;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory responder: acks after 'delay' wait cycles; optional spurious acks while idle.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 0;
    mem_data = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wcnt >= delay) begin
          mem_ack = 1;
          mem_data = mem[mem_addr];
          wcnt = 0;
        end else begin
          mem_ack = 0;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        mem_ack = noise && ($urandom_range(0, 1) == 1);
        mem_data = 8'($urandom);
      end
    end
  end

  initial begin
    prev_req = 0;
    prev_busy = 0;
    prev_addr = 0;
    forever begin
      @(negedge clk);
      if (we) wr_q.push_back({address, data, 32'(cyc)});
      if (mem_req && mem_ack) rd_q.push_back(mem_addr);
      if (done) begin
        done_q.push_back(cyc);
        if (busy || !prev_busy) busy_err++;
      end
      if (mem_req) req_n++;
      if (mem_req && prev_req && mem_addr !== prev_addr) stab_err++;
      prev_req = mem_req;
      prev_addr = mem_addr;
      prev_busy = busy;
    end
  end

  task automatic clear_mon();
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    req_n = 0;
    stab_err = 0;
    busy_err = 0;
  endtask

  task automatic fill_mem(input logic [15:0] base);
    for (int i = 0; i < NB; i++) mem[base + 16'(i)] = 8'($urandom);
  endtask

  // Reference: byte i lives at base+i (mod 2^16); each byte costs d+2 cycles, written d+1 cycles after its REQ starts.
  function automatic void build_exp(input logic [15:0] base, input int d, input int t);
    logic [15:0] a;
    exp_w.delete();
    exp_rd.delete();
    for (int i = 0; i < NB; i++) begin
      a = base + 16'(i);
      exp_rd.push_back(a);
      exp_w.push_back({4'(i), mem[a], 32'(t + 2 + d + i * (d + 2))});
    end
    exp_done = t + NB * (d + 2) + 1;
  endfunction

  task automatic run_transfer(input logic [15:0] base, input int d, input int ov,
                              input bit drop_en, output int t);
    clear_mon();
    delay = d;
    base_addr = base;
    @(posedge clk);
    #1;
    vsync = 1;
    t = cyc;
    for (int k = 1; k <= NB * (d + 2) + 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        vsync = 0;
        base_addr = 16'($urandom);
      end
      if (ov != 0 && k == ov) vsync = 1;
      if (ov != 0 && k == ov + 1) vsync = 0;
      if (drop_en && k == 3) enable = 0;
    end
    enable = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({mem_req, mem_addr, we, address, data, busy, done, overrun} !== 33'd0) begin
      fails++;
      $display("FAIL reset_in outputs got %h want 0",
               {mem_req, mem_addr, we, address, data, busy, done, overrun});
    end
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({mem_req, mem_addr, we, address, data, busy, done, overrun} !== 33'd0) begin
      fails++;
      $display("FAIL reset_out outputs got %h want 0",
               {mem_req, mem_addr, we, address, data, busy, done, overrun});
    end
  endtask

  task automatic test_basic();
    int t;
    logic [7:0] pat [0:9];
    pat = '{8'h3C, 8'h42, 8'h81, 8'h81, 8'h81, 8'h81, 8'h42, 8'h3C, 8'h50, 8'h20};
    for (int i = 0; i < NB; i++) mem[16'h1000 + 16'(i)] = pat[i];
    enable = 1;
    run_transfer(16'h1000, 0, 0, 0, t);
    build_exp(16'h1000, 0, t);
    tests++;
    if (wr_q.size() != NB) begin fails++; $display("FAIL basic_nwrites got %0d want %0d", wr_q.size(), NB); end
    for (int i = 0; i < NB; i++) begin
      w_t got;
      got = '0;
      if (i < wr_q.size()) got = wr_q[i];
      tests++;
      if (got !== exp_w[i]) begin
        fails++;
        $display("FAIL basic_write[%0d] got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                 i, got.a, got.d, got.c, exp_w[i].a, exp_w[i].d, exp_w[i].c);
      end
    end
    tests++;
    if (done_q.size() != 1 || done_q[0] != t + 21) begin
      fails++;
      $display("FAIL basic_done count=%0d first=%0d want one at %0d", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, t + 21);
    end
    tests++;
    if (busy_err != 0) begin fails++; $display("FAIL basic_busy_fall errors=%0d want 0", busy_err); end
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL basic_overrun got %b want 0", overrun); end
  endtask

  task automatic test_wait();
    int t;
    logic [15:0] b;
    b = 16'($urandom);
    fill_mem(b);
    run_transfer(b, 3, 0, 1, t);
    build_exp(b, 3, t);
    delay = 0;
    tests++;
    if (wr_q.size() != NB) begin fails++; $display("FAIL wait_nwrites got %0d want %0d", wr_q.size(), NB); end
    for (int i = 0; i < NB && i < wr_q.size(); i++) begin
      tests++;
      if (wr_q[i] !== exp_w[i]) begin
        fails++;
        $display("FAIL wait_write[%0d] got c=%0d d=%h want c=%0d d=%h",
                 i, wr_q[i].c, wr_q[i].d, exp_w[i].c, exp_w[i].d);
      end
    end
    tests++;
    if (done_q.size() != 1 || done_q[0] != t + 51) begin
      fails++;
      $display("FAIL wait_done count=%0d first=%0d want %0d", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, t + 51);
    end
    tests++;
    if (stab_err != 0) begin fails++; $display("FAIL wait_addr_stable changes=%0d want 0", stab_err); end
    tests++;
    if (req_n != NB * 4) begin fails++; $display("FAIL wait_req_cycles got %0d want %0d", req_n, NB * 4); end
  endtask

  task automatic test_wrap();
    int t;
    fill_mem(16'hFFFC);
    run_transfer(16'hFFFC, 1, 0, 0, t);
    build_exp(16'hFFFC, 1, t);
    delay = 0;
    tests++;
    if (rd_q.size() != NB) begin fails++; $display("FAIL wrap_nreads got %0d want %0d", rd_q.size(), NB); end
    for (int i = 0; i < NB && i < rd_q.size(); i++) begin
      tests++;
      if (rd_q[i] !== exp_rd[i]) begin
        fails++;
        $display("FAIL wrap_read[%0d] got %h want %h", i, rd_q[i], exp_rd[i]);
      end
    end
    tests++;
    if (wr_q.size() != NB || wr_q[NB-1] !== exp_w[NB-1]) begin
      fails++;
      $display("FAIL wrap_last_write n=%0d want n=%0d d=%h", wr_q.size(), NB, exp_w[NB-1].d);
    end
  endtask

  task automatic test_random();
    int t, d, bad;
    logic [15:0] b;
    noise = 1;
    for (int r = 0; r < 4; r++) begin
      b = 16'($urandom);
      d = $urandom_range(0, 2);
      fill_mem(b);
      run_transfer(b, d, 0, 0, t);
      build_exp(b, d, t);
      bad = (wr_q.size() != NB) ? 1 : 0;
      for (int i = 0; i < NB && i < wr_q.size(); i++) if (wr_q[i] !== exp_w[i]) bad++;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL rand_writes[%0d] base=%h d=%0d bad=%0d want 0", r, b, d, bad);
      end
      tests++;
      if (done_q.size() != 1 || done_q[0] != exp_done) begin
        fails++;
        $display("FAIL rand_done[%0d] count=%0d first=%0d want %0d", r, done_q.size(),
                 (done_q.size() > 0) ? done_q[0] : -1, exp_done);
      end
    end
    noise = 0;
    delay = 0;
  endtask

  task automatic test_enable_gating();
    int t;
    logic [15:0] b;
    clear_mon();
    enable = 0;
    @(posedge clk); #1; vsync = 1;
    repeat (3) @(posedge clk);
    #1; vsync = 0;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (req_n != 0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL gate_disabled req_cycles=%0d overrun=%b want 0 0", req_n, overrun);
    end
    vsync = 1;
    repeat (2) @(posedge clk);
    #1; enable = 1;
    repeat (20) @(posedge clk);
    #1;
    tests++;
    if (req_n != 0) begin fails++; $display("FAIL gate_held_high req_cycles=%0d want 0", req_n); end
    vsync = 0;
    @(posedge clk); #1;
    b = 16'($urandom);
    fill_mem(b);
    run_transfer(b, 0, 0, 0, t);
    build_exp(b, 0, t);
    tests++;
    if (wr_q.size() != NB || done_q.size() != 1 || done_q[0] != exp_done) begin
      fails++;
      $display("FAIL gate_fresh_rise writes=%0d dones=%0d want %0d 1", wr_q.size(), done_q.size(), NB);
    end
  endtask

  task automatic test_overrun();
    int t, bad;
    logic [15:0] b;
    b = 16'($urandom);
    fill_mem(b);
    run_transfer(b, 0, 6, 0, t);
    build_exp(b, 0, t);
    bad = (wr_q.size() != NB) ? 1 : 0;
    for (int i = 0; i < NB && i < wr_q.size(); i++) if (wr_q[i] !== exp_w[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL ovr_writes bad=%0d want 0", bad); end
    tests++;
    if (done_q.size() != 1 || done_q[0] != t + 21) begin
      fails++;
      $display("FAIL ovr_done count=%0d want one at %0d", done_q.size(), t + 21);
    end
    tests++;
    if (req_n != NB) begin fails++; $display("FAIL ovr_no_second req_cycles=%0d want %0d", req_n, NB); end
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    int t, bad;
    logic [15:0] b;
    b = 16'($urandom);
    fill_mem(b);
    clear_mon();
    base_addr = b;
    @(posedge clk); #1; vsync = 1;
    repeat (7) @(posedge clk);
    #2; reset = 0;
    #1;
    tests++;
    if ({mem_req, mem_addr, we, address, data, busy, done, overrun} !== 33'd0) begin
      fails++;
      $display("FAIL rstmid_async outputs got %h want 0",
               {mem_req, mem_addr, we, address, data, busy, done, overrun});
    end
    repeat (3) @(posedge clk);
    #1; reset = 1;
    clear_mon();
    repeat (25) @(posedge clk);
    #1;
    tests++;
    if (req_n != 0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_no_retrigger req_cycles=%0d overrun=%b want 0 0", req_n, overrun);
    end
    vsync = 0;
    @(posedge clk); #1;
    b = 16'($urandom);
    fill_mem(b);
    run_transfer(b, 0, 0, 0, t);
    build_exp(b, 0, t);
    bad = (wr_q.size() != NB) ? 1 : 0;
    for (int i = 0; i < NB && i < wr_q.size(); i++) if (wr_q[i] !== exp_w[i]) bad++;
    tests++;
    if (bad != 0 || done_q.size() != 1 || done_q[0] != exp_done) begin
      fails++;
      $display("FAIL rstmid_full_transfer bad=%0d dones=%0d want 0 1", bad, done_q.size());
    end
  endtask

  initial begin
    reset = 0;
    enable = 0;
    vsync = 0;
    base_addr = 0;
    test_reset();
    test_basic();
    test_wait();
    test_wrap();
    test_random();
    test_enable_gating();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Bus-master loader that refreshes the 10-byte sprite register file once per frame. On each rising edge of vsync, it fetches 10 consecutive bytes from main memory, starting at a programmable base address. Each byte is read through a req/ack read port and written into the sprite block through its write port (`we`/`address`/`data`): bytes 0–7 are bitmap rows, byte 8 is X, byte 9 is Y. The block sits between the memory arbiter and the sprite renderer, and replaces CPU-driven sprite writes.

## Interface
Parameters:
- `NUM_BYTES`, 10, bytes transferred per frame; range 1–16.
- `ADDR_W`, 16, width of the memory address.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: arms the vsync trigger.
- `vsync` in 1: frame sync from the video timing generator; synchronous to `clk`.
- `base_addr` in ADDR_W: memory address of sprite byte 0; latched at trigger.
- `mem_req` out 1: read request.
- `mem_addr` out ADDR_W: read address; stable while `mem_req` is high.
- `mem_ack` in 1: read complete; `mem_data` is valid in the same cycle.
- `mem_data` in 8: read data.
- `we` out 1: sprite register write strobe.
- `address` out 4: sprite register index.
- `data` out 8: sprite register write data.
- `busy` out 1: high while a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer ends.
- `overrun` out 1: sticky flag; a vsync edge arrived while the block was not IDLE.

## Operation
- FSM states: IDLE, REQ, WRITE, DONE.
- Edge detect: `vsync_d` is a register that holds the previous `vsync`. A trigger is `vsync & ~vsync_d`.
- IDLE:
  - Trigger with `enable`=1 → REQ.
  - On entry to REQ: latch `base_addr` into `base_q` and clear `idx` to 0.
  - Trigger with `enable`=0 is ignored.
- REQ:
  - `mem_req`=1 and `mem_addr`=`base_q`+`idx`, truncated to ADDR_W bits; the address wraps from 0xFFFF to 0x0000.
  - When `mem_ack`=1: capture `mem_data` into `data_q` and go to WRITE.
  - Otherwise stay in REQ, holding `mem_req` and `mem_addr`.
- WRITE:
  - Drive `we`=1, `address`=`idx`[3:0], `data`=`data_q` for exactly one cycle.
  - If `idx`==NUM_BYTES−1 → DONE; else increment `idx` and go to REQ.
- DONE: `done`=1 for one cycle, then → IDLE.
- `busy`=1 in REQ and WRITE, 0 in IDLE and DONE.
- A trigger in REQ, WRITE or DONE is dropped and sets `overrun`=1. Only reset clears `overrun`.
- `enable` deasserted mid-transfer: the current transfer still completes; only new triggers are blocked.
- `mem_ack` while `mem_req`=0 is ignored.
- `base_addr` changes after the trigger have no effect until the next transfer.
- Outside WRITE, `address` and `data` hold their last values; only `we` qualifies them.

## Timing
- Reset values: state IDLE, `idx`=0, `base_q`=0, `data_q`=0, `vsync_d`=1.
  - With `vsync_d`=1, a `vsync` already high at reset release does not trigger.
- Reset values of all outputs: `mem_req`=0, `mem_addr`=0, `we`=0, `address`=0, `data`=0, `busy`=0, `done`=0, `overrun`=0.
- Reset asserted mid-transfer: the transfer aborts immediately and all state returns to reset values. The sprite register file may be left partially updated.
- Trigger sampled at edge t: `mem_req`=1 and `busy`=1 from cycle t+1.
- Per byte: 1 REQ cycle plus wait cycles until ack, then 1 WRITE cycle.
  - With ack in the first REQ cycle, each byte takes 2 cycles and a full transfer takes 2·NUM_BYTES cycles, followed by the DONE cycle.
- Example with NUM_BYTES=10 and zero-wait ack: `we` pulses at cycles t+2, t+4, …, t+20 and `done` pulses at t+21.
- `we`, `address` and `data` are registered outputs. The byte acked in cycle c is written in cycle c+1.
- `mem_req`/`mem_addr` are registered. They drop or advance in the cycle after ack.

## Test plan
- Basic transfer:
  - Stimulus: memory at 0x1000–0x1009 holds 0x3C,0x42,0x81,0x81,0x81,0x81,0x42,0x3C,0x50,0x20; `base_addr`=0x1000; `enable`=1; one vsync rise; zero-wait ack.
  - Required: 10 `we` pulses with `address` 0–9 and matching data; `done` 21 cycles after the trigger; `busy` falls together with `done`.
- Wait states:
  - Stimulus: ack delayed 3 cycles on each byte.
  - Required: `mem_req`/`mem_addr` held stable throughout each wait; `we` only after ack; `done` at trigger+51.
- Overrun:
  - Stimulus: second vsync rise at trigger+6.
  - Required: transfer unaffected; `overrun`=1 and stays 1; no second transfer starts.
- Address wrap:
  - Stimulus: `base_addr`=0xFFFC.
  - Required: reads at 0xFFFC–0xFFFF then 0x0000–0x0005.
- Enable gating:
  - Stimulus: vsync rise with `enable`=0; then `enable`=1 with `vsync` held high.
  - Required: no `mem_req`; a trigger occurs only on the next fresh rise.
- Reset:
  - Stimulus: `reset` low at trigger+7.
  - Required: all outputs 0 asynchronously; `vsync` high at reset release causes no transfer; the next vsync rise performs a full 10-byte transfer.
